// File: rtl/regfile_write_ctrl.sv
// rtl/regfile_write_ctrl.sv - buffered write-back controller for the 64x32 register file
// Queues write requests, drains one per cycle into the RF write port, forwards pending data.
module regfile_write_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     rf_stall,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wa,
    output logic [DW-1:0]            rf_wd,
    input  logic [AW-1:0]            fwd_addr,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic                     idle,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign in_ready = (count != CW'(DEPTH));
    // Register 0 is hardwired to zero, so such writes complete the handshake but are dropped.
    assign push     = in_valid && in_ready && (in_addr != '0);
    assign pop      = (count != '0) && !rf_stall;
    assign idle     = (count == '0) && !rf_we;

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= in_addr;
            q_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rf_we  <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
                rf_wa  <= q_addr[rd_ptr];
                rf_wd  <= q_data[rd_ptr];
            end
            rf_we <= pop;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Output stage is the oldest pending write; later FIFO matches override it, youngest last.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (rf_we && (rf_wa == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = rf_wd;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if ((CW'(i) < count) && (q_addr[idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data[idx];
            end
        end
        if (fwd_addr == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb/tb_regfile_write_ctrl.sv - scoreboard bench for regfile_write_ctrl
module tb_regfile_write_ctrl;

    localparam int DEPTH = 4;
    localparam int AW    = 6;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          rf_stall;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic          idle;
    logic [$clog2(DEPTH):0] count;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  mcount   = 0;
    bit  mwe      = 1'b0;
    bit  last_acc = 1'b0;

    regfile_write_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rf_stall (rf_stall),
        .rf_we    (rf_we),
        .rf_wa    (rf_wa),
        .rf_wd    (rf_wd),
        .fwd_addr (fwd_addr),
        .fwd_hit  (fwd_hit),
        .fwd_data (fwd_data),
        .idle     (idle),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: decide the handshake from pre-edge values, advance the model, then check at negedge.
    task automatic tick();
        bit acc;
        bit stall;
        bit rst;
        bit push;
        bit pop;
        acc   = in_valid && in_ready && rst_n;
        stall = rf_stall;
        rst   = rst_n;
        @(posedge clk);
        if (!rst) begin
            sb.delete();
            mcount = 0;
            mwe    = 1'b0;
        end else begin
            push = acc && (in_addr != '0);
            pop  = (mcount > 0) && !stall;
            if (push) sb.push_back('{addr: in_addr, data: in_data});
            mcount = mcount + int'(push) - int'(pop);
            mwe    = pop;
        end
        last_acc = acc;
        @(negedge clk);
        check("count", 32'(count), 32'(mcount));
        check("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
        check("rf_we", 32'(rf_we), 32'(mwe));
        check("idle", 32'(idle), 32'(mcount == 0 && !mwe));
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input int budget);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        do begin
            tick();
            n++;
        end while (!last_acc && n < budget);
        if (!last_acc) check("send_timeout", 32'(n), 32'(budget + 1));
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_we", 32'(rf_wa), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("rf_wa", 32'(rf_wa), 32'(e.addr));
                check("rf_wd", rf_wd, e.data);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        rf_stall = 1'b0;
        fwd_addr = 6'd5;
        @(negedge clk);
        tick();
        tick();
        check("rst_fwd_hit", 32'(fwd_hit), 32'd0);
        check("rst_fwd_data", fwd_data, 32'd0);
        check("rst_wa", 32'(rf_wa), 32'd0);
        rst_n = 1'b1;

        // Single write, two-edge latency
        send(6'd5, 32'hDEAD_BEEF, 4);
        check("lat_we_n", 32'(rf_we), 32'd0);
        tick();
        check("lat_we", 32'(rf_we), 32'd1);
        check("lat_wa", 32'(rf_wa), 32'd5);
        check("lat_wd", rf_wd, 32'hDEAD_BEEF);
        tick();
        check("lat_idle", 32'(idle), 32'd1);

        // Register 0 is dropped
        send(6'd0, 32'h1234_5678, 4);
        check("r0_acc", 32'(last_acc), 32'd1);
        check("r0_count", 32'(count), 32'd0);
        fwd_addr = 6'd0;
        #1 check("r0_fwd_hit", 32'(fwd_hit), 32'd0);
        repeat (3) tick();

        // Stall: fill, block the fifth, then drain in order
        rf_stall = 1'b1;
        for (int k = 1; k <= 4; k++) send(AW'(k), 32'(k * 'h11), 4);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_addr  = 6'd5;
        in_data  = 32'h55;
        repeat (3) tick();
        check("held_5th", 32'(last_acc), 32'd0);
        rf_stall = 1'b0;
        send(6'd5, 32'h55, 4);
        repeat (8) tick();

        // Forwarding with duplicates
        rf_stall = 1'b1;
        send(6'd7, 32'hA, 4);
        send(6'd7, 32'hB, 4);
        send(6'd9, 32'hC, 4);
        fwd_addr = 6'd7;
        #1 check("fwd7_hit", 32'(fwd_hit), 32'd1);
        check("fwd7_data", fwd_data, 32'hB);
        fwd_addr = 6'd9;
        #1 check("fwd9_data", fwd_data, 32'hC);
        fwd_addr = 6'd8;
        #1 check("fwd8_hit", 32'(fwd_hit), 32'd0);
        check("fwd8_data", fwd_data, 32'd0);
        rf_stall = 1'b0;
        tick();
        fwd_addr = 6'd7;
        #1 check("fwd7_after_pop", fwd_data, 32'hB);
        repeat (5) tick();
        fwd_addr = 6'd9;
        #1 check("fwd_drained", 32'(fwd_hit), 32'd0);

        // Steady push+pop at count=2 across pointer wrap
        rf_stall = 1'b1;
        send(6'd20, 32'h2020, 4);
        send(6'd21, 32'h2121, 4);
        rf_stall = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_addr  = AW'(30 + i);
            in_data  = $urandom;
            tick();
            check("steady_acc", 32'(last_acc), 32'd1);
            check("steady_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        repeat (5) tick();

        // Reset mid-drain
        rf_stall = 1'b1;
        for (int k = 0; k < 4; k++) send(AW'(40 + k), 32'(k + 100), 4);
        rf_stall = 1'b0;
        tick();
        check("pre_rst_we", 32'(rf_we), 32'd1);
        check("pre_rst_count", 32'(count), 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("post_rst_wa", 32'(rf_wa), 32'd0);
        check("post_rst_wd", rf_wd, 32'd0);
        check("post_rst_idle", 32'(idle), 32'd1);
        repeat (6) tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
